// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit that owns the HI/LO registers.
// MULT/MULTU/DIV/DIVU run over a fixed number of busy cycles. MTHI and MTLO
// complete in the cycle they are accepted. The unit raises stall_req for the
// hazard unit while an MDU op occupies it.
// Define MDU_MADD_EN to enable MADD (op 7) and MADDU (op 8). These ops
// accumulate into {HI,LO} and take MULT_CYCLES.
// Without MDU_MADD_EN, ops 7 and 8 behave as NONE.
// Handshake: the unit accepts an op when start=1, req=0 and busy=0 in the
// same cycle, and op is a recognised code. The op is then committed. Only a
// reset can abandon it, and a later req cannot. start while busy is ignored.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        read_hi,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_lo_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    localparam logic [15:0] MULT_N = 16'(MULT_CYCLES);
    localparam logic [15:0] DIV_N  = 16'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        is_mul;
    logic        is_div;
    logic        is_long;
    logic        accept;
    logic        finish;
    logic        res_we;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_ovf;
    logic [31:0] safe_b;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Classify the incoming op; multi-cycle ops are the ones that raise busy.
    always_comb begin
        is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU);
`endif
        is_div  = (op == OP_DIV) || (op == OP_DIVU);
        is_long = is_mul || is_div;
    end

    assign busy      = (state == S_RUN);
    assign accept    = start && !req && !busy;
    assign finish    = busy && (cnt == 16'd1);
    assign stall_req = d_md_use && (busy || (start && is_long));
    assign hi_lo_out = read_hi ? hi : lo;

    // State register for the idle/run sequencer.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state: enter RUN on a long op, leave when the counter expires.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept && is_long) state_next = S_RUN;
            S_RUN:  if (cnt == 16'd1)      state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Arithmetic on the latched operands, written to HI/LO only at completion.
    always_comb begin
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        // The most-negative / -1 case overflows; a divisor of 1 keeps the
        // divider well defined and gives the wrapped quotient directly.
        div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        safe_b  = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
        quot_s  = $signed(a_q) / $signed(safe_b);
        rem_s   = $signed(a_q) % $signed(safe_b);
        res_we  = 1'b1;
        res_hi  = hi;
        res_lo  = lo;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_we = (b_q != 32'd0);
                res_lo = quot_s;
                res_hi = rem_s;
            end
            OP_DIVU: begin
                res_we = (b_q != 32'd0);
                res_lo = a_q / safe_b;
                res_hi = a_q % safe_b;
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
`endif
            default: res_we = 1'b0;
        endcase
    end

    // Counter, operand latches and HI/LO updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 16'd0;
            op_q <= 4'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (accept) begin
            if (is_long) begin
                cnt  <= is_div ? DIV_N : MULT_N;
                op_q <= op;
                a_q  <= rs_val;
                b_q  <= rt_val;
            end else if (op == OP_MTHI) begin
                hi <= rs_val;
            end else if (op == OP_MTLO) begin
                lo <= rs_val;
            end
        end else if (busy) begin
            cnt <= cnt - 16'd1;
            if (finish && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed bench for e_mdu. The driver pushes {busy_len, HI, LO}
// for every multi-cycle op. The monitor pops one entry on each falling edge
// of busy and compares it.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        read_hi;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_lo_out;

    logic [71:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_prev = 1'b0;
    int          mon_len = 0;
    logic [71:0] mon_e;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .read_hi(read_hi),
        .d_md_use(d_md_use), .busy(busy), .stall_req(stall_req),
        .hi_lo_out(hi_lo_out)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        step();
        start = 1'b0;
        op    = 4'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 60) begin
            step();
            n++;
        end
        if (busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_idle busy still %b after %0d cycles", busy, n);
        end
        step();
    endtask

    task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        read_hi = 1'b1;
        #1 chk({name, "_hi"}, hi_lo_out, eh);
        read_hi = 1'b0;
        #1 chk({name, "_lo"}, hi_lo_out, el);
    endtask

    // Monitor: on each busy fall, check run length and HI/LO against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (busy === 1'b1) mon_len++;
            if (mon_prev && busy !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion len=%0d required none", mon_len);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("busy_len", 32'(mon_len), {24'd0, mon_e[71:64]});
                    read_hi = 1'b1;
                    #1 chk("done_hi", hi_lo_out, mon_e[63:32]);
                    read_hi = 1'b0;
                    #1 chk("done_lo", hi_lo_out, mon_e[31:0]);
                end
                mon_len = 0;
            end
            mon_prev = (busy === 1'b1);
        end
    end

    // Driver: directed sequences.
    initial begin
        reset = 1'b1; req = 1'b0; start = 1'b0; op = 4'd0;
        rs_val = 32'd0; rt_val = 32'd0; read_hi = 1'b0; d_md_use = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, stall_req}, 32'd0);
        check_hilo("reset", 32'd0, 32'd0);
        d_md_use = 1'b0;

        // MTHI / MTLO are single cycle
        issue(4'd5, 32'h1234_5678, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(4'd6, 32'h0000_0009, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        check_hilo("mt", 32'h1234_5678, 32'h0000_0009);

        // Multiplies
        exp_q.push_back({8'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        exp_q.push_back({8'd5, 32'h0000_0002, 32'hFFFF_FFFA});
        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle();

        // Divides, including divide-by-zero and the overflow case
        exp_q.push_back({8'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        exp_q.push_back({8'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(4'd3, 32'd55, 32'd0);
        wait_idle();
        exp_q.push_back({8'd10, 32'h0000_0000, 32'h8000_0000});
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        exp_q.push_back({8'd10, 32'd2, 32'd14});
        issue(4'd4, 32'd100, 32'd7);
        wait_idle();

        // req cancels a start in the same cycle
        req = 1'b1;
        issue(4'd3, 32'd7, 32'd2);
        req = 1'b0;
        chk("req_div_busy", {31'd0, busy}, 32'd0);
        req = 1'b1;
        issue(4'd5, 32'h0000_AAAA, 32'd0);
        req = 1'b0;
        check_hilo("req_cancel", 32'd2, 32'd14);

        // req on the third busy cycle does not abort
        exp_q.push_back({8'd10, 32'd1, 32'd3});
        issue(4'd4, 32'd7, 32'd2);
        step();
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        wait_idle();

        // stall_req window, plus an MTHI attempted while busy
        exp_q.push_back({8'd5, 32'd0, 32'd35});
        d_md_use = 1'b1;
        start = 1'b1; op = 4'd1; rs_val = 32'd5; rt_val = 32'd7;
        @(negedge clk);
        chk("stall_accept", {31'd0, stall_req}, 32'd1);
        step();
        start = 1'b0; op = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin start = 1'b1; op = 4'd5; rs_val = 32'h0000_DEAD; end
            if (i == 3) begin start = 1'b0; op = 4'd0; end
            @(negedge clk);
            chk($sformatf("stall_busy%0d", i), {31'd0, stall_req}, 32'd1);
            step();
        end
        @(negedge clk);
        chk("stall_after", {31'd0, stall_req}, 32'd0);
        step();
        start = 1'b1; op = 4'd9; rs_val = 32'd3; rt_val = 32'd4;
        #1 chk("stall_op9", {31'd0, stall_req}, 32'd0);
        step();
        start = 1'b0; op = 4'd0;
        chk("op9_busy", {31'd0, busy}, 32'd0);
        d_md_use = 1'b0;
        step();

        // reset in the middle of a divide
        exp_q.push_back({8'd3, 32'd0, 32'd0});
        issue(4'd3, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);
        step();
        step();

`ifdef MDU_MADD_EN
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        exp_q.push_back({8'd5, 32'd1, 32'd0});
        issue(4'd8, 32'd1, 32'd1);
        wait_idle();
        exp_q.push_back({8'd5, 32'd0, 32'hFFFF_FFFF});
        issue(4'd7, 32'hFFFF_FFFF, 32'd1);
        wait_idle();
`else
        d_md_use = 1'b1;
        start = 1'b1; op = 4'd7; rs_val = 32'd3; rt_val = 32'd4;
        #1 chk("madd_off_stall", {31'd0, stall_req}, 32'd0);
        step();
        start = 1'b0; op = 4'd0;
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        check_hilo("madd_off", 32'd0, 32'd0);
        d_md_use = 1'b0;
`endif

        // Drain the scoreboard, bounded
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
